agc_rupt_ctrl: RTL and testbench
================================

Name: agc_rupt_ctrl

Overview:
- Priority interrupt (RUPT) controller for the AGC datapath.
- Latches interrupt requests from timers, the keyboard, uplink/downlink, radar and the hand controller.
- At an instruction boundary, asks the control-pulse sequencer to divert into the interrupt entry sequence: save Z/B to ZRUPT/BRUPT, then load Z with a vector address.
- Blocks further interrupts until RESUME, and enforces INHINT/RELINT, extracode and A-overflow lockouts.

Parameters:
- NUM_RUPT, 10: number of request lines. Index 0 is highest priority (T6RUPT); index 9 is lowest (HANDRUPT).
- VEC_BASE, 12'h800: base of fixed-fixed vector table (octal 4000, the restart entry).
- VEC_STRIDE, 4: words per vector slot.

Ports:
- clk, in, 1: system clock, rising edge.
- rst_n, in, 1: asynchronous active-low reset.
- rupt_req, in, NUM_RUPT: raw request lines. Edge-sensitive: only a 0->1 transition posts a request.
- inst_boundary, in, 1: sequencer is at the last pulse of an instruction. One-cycle qualifier.
- ext_flag, in, 1: extracode prefix pending. Blocks interrupt entry.
- a_ovf, in, 1: regA[15]!=regA[14]. Blocks interrupt entry.
- inhint, in, 1: INHINT executed, one-cycle pulse.
- relint, in, 1: RELINT executed, one-cycle pulse.
- resume, in, 1: RESUME executed, one-cycle pulse.
- take_ack, in, 1: sequencer has saved Z/B and loaded Z with rupt_vec.
- take_req, out, 1: interrupt entry request.
- rupt_vec, out, 12: vector address for Z.
- rupt_id, out, 4: index of the request being serviced.
- rupt_active, out, 1: inside an ISR.
- inhibit, out, 1: INHINT state.
- pending, out, NUM_RUPT: latched pending requests.
- err_resume, out, 1: sticky flag, set when RESUME arrives outside an ISR.

Behaviour:
- Reset (async, rst_n=0) forces:
  - state=IDLE
  - pending=0, prev_req=0, inhibit=0, err_resume=0
  - take_req=0, rupt_vec=0, rupt_id=0, rupt_active=0
- Reset mid-REQ or mid-ACTIVE aborts the entry or ISR, and all pending requests are lost.
- A line held high through reset release posts one request (prev_req=0).
- Edge detect: prev_req <= rupt_req each clock. A bit sets in pending at the clock edge where rupt_req & ~prev_req is true.
- Pending clear: pending[rupt_id] clears on take_ack in REQ. If a new edge on the same bit coincides with the clear, the set wins.
- Inhibit: inhint sets it, relint clears it. If both arrive in the same cycle, inhint wins. Inhibit persists across ISRs.
- IDLE -> REQ when all of these hold at a clock edge:
  - |pending
  - inst_boundary
  - !inhibit, !ext_flag, !a_ovf
- On the IDLE -> REQ transition:
  - rupt_id <= lowest set index of pending.
  - rupt_vec <= VEC_BASE + VEC_STRIDE*(rupt_id+1), 12-bit modulo (id 0 -> 12'h804, id 9 -> 12'h828).
  - take_req <= 1.
- REQ:
  - take_req, rupt_id and rupt_vec are held stable until take_ack.
  - Higher-priority requests arriving in REQ do not preempt the selected id.
  - On take_ack: take_req <= 0, clear pending[rupt_id], rupt_active <= 1, go to ACTIVE.
  - Holding take_ack high for several cycles has no further effect.
- ACTIVE:
  - No new entry, regardless of pending or boundary. New edges still latch into pending.
  - On resume: rupt_active <= 0, go to IDLE.
  - A new entry needs a later inst_boundary; entry in the same cycle as resume is not allowed.
- resume in IDLE or REQ: ignored for state, sets err_resume (sticky until reset). take_ack outside REQ: ignored.
- Latency: minimum 2 clocks from a rupt_req rise to take_req high (edge at k, boundary sampled at k+1, take_req high after edge k+1).
- Minimum 1 cycle from take_ack to rupt_active.
- RTL is registered only; no combinational path from any input to any output.

Test Plan:
- Reset, pulse rupt_req[3] at cycle 2, inst_boundary at cycle 3 -> take_req=1 after edge 3, rupt_id=3, rupt_vec=12'h810. take_ack -> pending=0, rupt_active=1. resume -> IDLE, rupt_active=0.
- rupt_req[5] and rupt_req[1] rise in the same cycle, then boundary -> rupt_id=1, rupt_vec=12'h808, pending[5] still set. Service id 1, resume, boundary -> rupt_id=5, rupt_vec=12'h818.
- inhint pulse, then rupt_req[0] rise and 3 boundaries -> take_req stays 0, pending[0]=1. inhint+relint in the same cycle -> inhibit=1. relint, then boundary -> take_req=1, rupt_vec=12'h804.
- pending[2] set with ext_flag=1 (or a_ovf=1) at boundary -> no take_req. Clear the flag, next boundary -> take_req=1, rupt_id=2.
- During ACTIVE (id 4), rupt_req[0] rises -> pending[0]=1, no take_req. Same-cycle take_ack and new rupt_req[4] edge -> pending[4] stays 1.
- resume pulse in IDLE -> err_resume=1, state unchanged. Assert rst_n=0 while in REQ -> all outputs 0 immediately (async), pending cleared.

Source files
------------

// File: rtl/agc_rupt_if.sv
// Handshake bundle between the AGC control-pulse sequencer and the RUPT controller.
// The sequencer drives the master side; the controller sits on the slave side.
interface agc_rupt_if #(
    parameter int NUM_RUPT = 10
);
    logic [NUM_RUPT-1:0] rupt_req;
    logic                inst_boundary;
    logic                ext_flag;
    logic                a_ovf;
    logic                inhint;
    logic                relint;
    logic                resume;
    logic                take_ack;

    logic                take_req;
    logic [11:0]         rupt_vec;
    logic [3:0]          rupt_id;
    logic                rupt_active;
    logic                inhibit;
    logic [NUM_RUPT-1:0] pending;
    logic                err_resume;

    modport master (
        output rupt_req, inst_boundary, ext_flag, a_ovf, inhint, relint, resume, take_ack,
        input  take_req, rupt_vec, rupt_id, rupt_active, inhibit, pending, err_resume
    );

    modport slave (
        input  rupt_req, inst_boundary, ext_flag, a_ovf, inhint, relint, resume, take_ack,
        output take_req, rupt_vec, rupt_id, rupt_active, inhibit, pending, err_resume
    );
endinterface

// File: rtl/agc_rupt_ctrl.sv
// Priority interrupt controller: latches request edges, diverts the sequencer into
// the RUPT entry sequence at instruction boundaries, and blocks nesting until RESUME.
module agc_rupt_ctrl #(
    parameter int          NUM_RUPT   = 10,
    parameter logic [11:0] VEC_BASE   = 12'h800,
    parameter int          VEC_STRIDE = 4
) (
    input logic       clk,
    input logic       rst_n,
    agc_rupt_if.slave bus
);
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_REQ    = 2'd1;
    localparam logic [1:0] ST_ACTIVE = 2'd2;

    logic [1:0]          state_reg, state_next;
    logic [NUM_RUPT-1:0] prev_req_reg;
    logic [NUM_RUPT-1:0] pending_reg, pending_next;
    logic                inhibit_reg, inhibit_next;
    logic                err_reg, err_next;
    logic                take_reg, take_next;
    logic [11:0]         vec_reg, vec_next;
    logic [3:0]          id_reg, id_next;
    logic                active_reg, active_next;

    logic [NUM_RUPT-1:0] rise;
    logic [NUM_RUPT-1:0] clr_mask;
    logic                ack_take;
    logic                can_enter;
    logic [3:0]          sel_id;
    logic [11:0]         sel_vec;

    assign ack_take = (state_reg == ST_REQ) && bus.take_ack;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_RUPT; gi++) begin : g_line
            assign rise[gi]     = bus.rupt_req[gi] & ~prev_req_reg[gi];
            assign clr_mask[gi] = ack_take && (id_reg == 4'(gi));
        end
    endgenerate

    // Lowest index wins: scan downward so the final assignment is the smallest set bit.
    always_comb begin
        sel_id = '0;
        for (int i = NUM_RUPT - 1; i >= 0; i--) begin
            if (pending_reg[i]) sel_id = 4'(i);
        end
    end

    assign sel_vec   = VEC_BASE + 12'(VEC_STRIDE * (int'(sel_id) + 1));
    assign can_enter = (|pending_reg) && bus.inst_boundary && !inhibit_reg
                       && !bus.ext_flag && !bus.a_ovf;

    // A new edge is ORed in after the service clear so a coincident re-request survives.
    assign pending_next = (pending_reg & ~clr_mask) | rise;
    assign inhibit_next = bus.inhint | (inhibit_reg & ~bus.relint);
    assign err_next     = err_reg | (bus.resume && (state_reg != ST_ACTIVE));

    always_comb begin
        state_next  = state_reg;
        take_next   = take_reg;
        vec_next    = vec_reg;
        id_next     = id_reg;
        active_next = active_reg;
        case (state_reg)
            ST_IDLE: begin
                if (can_enter) begin
                    state_next = ST_REQ;
                    id_next    = sel_id;
                    vec_next   = sel_vec;
                    take_next  = 1'b1;
                end
            end
            ST_REQ: begin
                if (bus.take_ack) begin
                    state_next  = ST_ACTIVE;
                    take_next   = 1'b0;
                    active_next = 1'b1;
                end
            end
            ST_ACTIVE: begin
                if (bus.resume) begin
                    state_next  = ST_IDLE;
                    active_next = 1'b0;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= ST_IDLE;
            prev_req_reg <= '0;
            pending_reg  <= '0;
            inhibit_reg  <= 1'b0;
            err_reg      <= 1'b0;
            take_reg     <= 1'b0;
            vec_reg      <= '0;
            id_reg       <= '0;
            active_reg   <= 1'b0;
        end else begin
            state_reg    <= state_next;
            prev_req_reg <= bus.rupt_req;
            pending_reg  <= pending_next;
            inhibit_reg  <= inhibit_next;
            err_reg      <= err_next;
            take_reg     <= take_next;
            vec_reg      <= vec_next;
            id_reg       <= id_next;
            active_reg   <= active_next;
        end
    end

    assign bus.take_req    = take_reg;
    assign bus.rupt_vec    = vec_reg;
    assign bus.rupt_id     = id_reg;
    assign bus.rupt_active = active_reg;
    assign bus.inhibit     = inhibit_reg;
    assign bus.pending     = pending_reg;
    assign bus.err_resume  = err_reg;
endmodule

// File: tb/tb_agc_rupt_ctrl.sv
// Scoreboard bench for agc_rupt_ctrl: directed scenarios then random traffic,
// every cycle compared against a behavioural model of the interrupt rules.
module tb_agc_rupt_ctrl;
    localparam logic [6:0] K_B  = 7'd1;   // inst_boundary
    localparam logic [6:0] K_E  = 7'd2;   // ext_flag
    localparam logic [6:0] K_O  = 7'd4;   // a_ovf
    localparam logic [6:0] K_IH = 7'd8;   // inhint
    localparam logic [6:0] K_RL = 7'd16;  // relint
    localparam logic [6:0] K_RS = 7'd32;  // resume
    localparam logic [6:0] K_AK = 7'd64;  // take_ack

    typedef struct packed {
        logic        take;
        logic [11:0] vec;
        logic [3:0]  id;
        logic        act;
        logic        inh;
        logic [9:0]  pend;
        logic        err;
    } snap_t;

    logic clk;
    logic rst_n;
    agc_rupt_if #(.NUM_RUPT(10)) bus ();

    agc_rupt_ctrl #(.NUM_RUPT(10), .VEC_BASE(12'h800), .VEC_STRIDE(4)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int    total = 0;
    int    bad   = 0;
    snap_t exp_q[$];

    // Model: 0 = waiting for an interrupt, 1 = entry requested, 2 = servicing.
    int          m_mode;
    logic [9:0]  m_prev, m_pending;
    logic [3:0]  m_id;
    logic [11:0] m_vec;
    logic        m_take, m_active, m_inhibit, m_err;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic model_reset();
        m_mode = 0; m_prev = '0; m_pending = '0; m_id = '0; m_vec = '0;
        m_take = 0; m_active = 0; m_inhibit = 0; m_err = 0;
    endtask

    task automatic model_step(input logic [9:0] req, input logic [6:0] k);
        logic [9:0] rise;
        int         low;
        bit         enter;
        rise  = req & ~m_prev;
        low   = -1;
        for (int i = 0; i < 10; i++) if (m_pending[i] && low < 0) low = i;
        enter = (m_mode == 0) && (m_pending != 0) && k[0] && !m_inhibit && !k[1] && !k[2];
        if (k[5] && m_mode != 2) m_err = 1'b1;
        if (m_mode == 1 && k[6]) m_pending[m_id] = 1'b0;
        m_pending = m_pending | rise;
        if (m_mode == 0 && enter) begin
            m_mode = 1; m_take = 1; m_id = 4'(low);
            m_vec  = 12'h800 + 12'(4 * (low + 1));
        end else if (m_mode == 1 && k[6]) begin
            m_mode = 2; m_take = 0; m_active = 1;
        end else if (m_mode == 2 && k[5]) begin
            m_mode = 0; m_active = 0;
        end
        if (k[3]) m_inhibit = 1'b1;
        else if (k[4]) m_inhibit = 1'b0;
        m_prev = req;
    endtask

    task automatic apply(input logic [9:0] req, input logic [6:0] k);
        bus.rupt_req      = req;
        bus.inst_boundary = k[0];
        bus.ext_flag      = k[1];
        bus.a_ovf         = k[2];
        bus.inhint        = k[3];
        bus.relint        = k[4];
        bus.resume        = k[5];
        bus.take_ack      = k[6];
        model_step(req, k);
        exp_q.push_back('{m_take, m_vec, m_id, m_active, m_inhibit, m_pending, m_err});
    endtask

    task automatic drive(input logic [9:0] req, input logic [6:0] k);
        @(negedge clk);
        apply(req, k);
    endtask

    task automatic settle();
        @(posedge clk);
        #2;
    endtask

    // Asserts rst_n between edges, checks the async clear, then releases with inputs held.
    task automatic do_reset();
        logic [6:0] k;
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst take_req", 32'(bus.take_req), 32'd0);
        check("rst rupt_vec", 32'(bus.rupt_vec), 32'd0);
        check("rst rupt_id", 32'(bus.rupt_id), 32'd0);
        check("rst rupt_active", 32'(bus.rupt_active), 32'd0);
        check("rst inhibit", 32'(bus.inhibit), 32'd0);
        check("rst pending", 32'(bus.pending), 32'd0);
        check("rst err_resume", 32'(bus.err_resume), 32'd0);
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        k = {bus.take_ack, bus.resume, bus.relint, bus.inhint, bus.a_ovf, bus.ext_flag, bus.inst_boundary};
        apply(bus.rupt_req, k);
    endtask

    // Monitor: compares every post-edge output snapshot against the queued expectation.
    initial begin : monitor
        snap_t e;
        logic  last_take;
        last_take = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (rst_n && exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("take_req", 32'(bus.take_req), 32'(e.take));
                check("rupt_vec", 32'(bus.rupt_vec), 32'(e.vec));
                check("rupt_id", 32'(bus.rupt_id), 32'(e.id));
                check("rupt_active", 32'(bus.rupt_active), 32'(e.act));
                check("inhibit", 32'(bus.inhibit), 32'(e.inh));
                check("pending", 32'(bus.pending), 32'(e.pend));
                check("err_resume", 32'(bus.err_resume), 32'(e.err));
                if (e.take && !last_take)
                    $display("entry id=%0d vec=%03h pending=%03h", e.id, e.vec, e.pend);
                last_take = e.take;
            end
        end
    end

    initial begin : stimulus
        rst_n = 1'b1;
        bus.rupt_req = '0;
        bus.inst_boundary = 0; bus.ext_flag = 0; bus.a_ovf = 0;
        bus.inhint = 0; bus.relint = 0; bus.resume = 0; bus.take_ack = 0;
        model_reset();
        do_reset();

        // Single request through entry, service and resume.
        drive(10'h008, 0);
        drive(10'h000, K_B); settle();
        check("t1 take_req", 32'(bus.take_req), 32'd1);
        check("t1 rupt_id", 32'(bus.rupt_id), 32'd3);
        check("t1 rupt_vec", 32'(bus.rupt_vec), 32'h810);
        drive(10'h000, K_AK); settle();
        check("t1 pending", 32'(bus.pending), 32'd0);
        check("t1 active", 32'(bus.rupt_active), 32'd1);
        drive(10'h000, K_RS); settle();
        check("t1 resumed", 32'(bus.rupt_active), 32'd0);

        // Two simultaneous requests: priority order.
        drive(10'h022, 0);
        drive(10'h000, K_B); settle();
        check("t2 first id", 32'(bus.rupt_id), 32'd1);
        check("t2 first vec", 32'(bus.rupt_vec), 32'h808);
        check("t2 pending5", 32'(bus.pending[5]), 32'd1);
        drive(10'h000, K_AK);
        drive(10'h000, K_RS);
        drive(10'h000, K_B); settle();
        check("t2 second id", 32'(bus.rupt_id), 32'd5);
        check("t2 second vec", 32'(bus.rupt_vec), 32'h818);
        drive(10'h000, K_AK);
        drive(10'h000, K_RS);

        // Inhibit lockout and inhint/relint collision.
        drive(10'h000, K_IH);
        drive(10'h001, 0);
        drive(10'h000, K_B);
        drive(10'h000, K_B);
        drive(10'h000, K_B); settle();
        check("t3 inhibited", 32'(bus.take_req), 32'd0);
        check("t3 pending0", 32'(bus.pending[0]), 32'd1);
        drive(10'h000, K_IH | K_RL); settle();
        check("t3 inhint wins", 32'(bus.inhibit), 32'd1);
        drive(10'h000, K_RL);
        drive(10'h000, K_B); settle();
        check("t3 take_req", 32'(bus.take_req), 32'd1);
        check("t3 vec", 32'(bus.rupt_vec), 32'h804);
        drive(10'h000, K_AK);
        drive(10'h000, K_RS);

        // Extracode and overflow lockouts.
        drive(10'h004, 0);
        drive(10'h000, K_B | K_E);
        drive(10'h000, K_B | K_O); settle();
        check("t4 locked", 32'(bus.take_req), 32'd0);
        drive(10'h000, K_B); settle();
        check("t4 take_req", 32'(bus.take_req), 32'd1);
        check("t4 id", 32'(bus.rupt_id), 32'd2);
        drive(10'h000, K_AK);
        drive(10'h000, K_RS);

        // Activity during an ISR and a re-request colliding with its own clear.
        drive(10'h010, 0);
        drive(10'h000, K_B);
        drive(10'h010, K_AK); settle();
        check("t5 set wins", 32'(bus.pending[4]), 32'd1);
        drive(10'h001, 0);
        drive(10'h000, K_B); settle();
        check("t5 pending0", 32'(bus.pending[0]), 32'd1);
        check("t5 no nest", 32'(bus.take_req), 32'd0);
        drive(10'h000, K_RS);
        drive(10'h000, K_RS); settle();
        check("t6 err_resume", 32'(bus.err_resume), 32'd1);
        check("t6 idle", 32'(bus.rupt_active), 32'd0);
        drive(10'h000, K_B);
        do_reset();

        // Random traffic with occasional mid-run resets.
        for (int c = 0; c < 2100; c++) begin
            logic [9:0] r;
            logic [6:0] k;
            r = bus.rupt_req;
            for (int b = 0; b < 10; b++) if ($urandom_range(0, 11) == 0) r[b] = ~r[b];
            k = '0;
            if ($urandom_range(0, 9) < 4) k = k | K_B;
            if ($urandom_range(0, 9) == 0) k = k | K_E;
            if ($urandom_range(0, 9) == 0) k = k | K_O;
            if ($urandom_range(0, 19) == 0) k = k | K_IH;
            if ($urandom_range(0, 9) == 0) k = k | K_RL;
            if ($urandom_range(0, (m_mode == 2) ? 4 : 39) == 0) k = k | K_RS;
            if ($urandom_range(0, (m_mode == 1) ? 2 : 19) == 0) k = k | K_AK;
            drive(r, k);
            if (c % 700 == 699) do_reset();
        end

        @(posedge clk);
        #3;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
